// File: rtl/rprelu_pkg.sv
// Shared types and constants for the RPReLU parameter loader.
// PARA_WIDTH falls back to 16 bits when no global definition is supplied.
// Optional feature macro: RPRELU_PARA_SHADOW_EN (shadow copy with atomic commit).
`ifndef PARA_WIDTH
`define PARA_WIDTH 16
`endif

package rprelu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_BETA,
      LOAD_GAMMA,
      LOAD_ZETA,
      DONE
   } rprelu_ld_state_t;

   localparam logic MODE_RELOAD = 1'b0;
   localparam logic MODE_CALC   = 1'b1;

   // beta, gamma and zeta sections in stream order
   localparam int SECTION_NUM = 3;

endpackage

// File: rtl/rprelu_para_bank.sv
// One per-channel parameter array (beta, gamma or zeta) with an addressed write port.
// With RPRELU_PARA_SHADOW_EN defined, writes land in a shadow copy and the visible
// array takes the whole shadow (including a same-cycle write) when commit is high.
// Without it, writes go straight to the visible array and commit is ignored.
module rprelu_para_bank
   import rprelu_pkg::*;
#(
   parameter int CHANNEL_NUM = 512,
   parameter int PARA_WIDTH  = 16,
   parameter int CNT_W       = $clog2(CHANNEL_NUM)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic [CNT_W-1:0]             wr_addr,
   input  logic signed [PARA_WIDTH-1:0] wr_data,
   input  logic                         commit,
   output logic signed [PARA_WIDTH-1:0] data_out [CHANNEL_NUM]
);

   logic signed [PARA_WIDTH-1:0] arr_q [CHANNEL_NUM];
   logic signed [PARA_WIDTH-1:0] arr_d [CHANNEL_NUM];

`ifdef RPRELU_PARA_SHADOW_EN
   logic signed [PARA_WIDTH-1:0] shadow_q [CHANNEL_NUM];
   logic signed [PARA_WIDTH-1:0] shadow_d [CHANNEL_NUM];

   // Fill the shadow; on commit the visible array takes the shadow merged with this cycle's word.
   always_comb begin
      shadow_d = shadow_q;
      if (wr_en) begin
         shadow_d[wr_addr] = wr_data;
      end
      arr_d = arr_q;
      if (commit) begin
         arr_d = shadow_d;
      end
   end

   // Register visible and shadow arrays; reset clears both.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CHANNEL_NUM; i++) begin
            arr_q[i]    <= '0;
            shadow_q[i] <= '0;
         end
      end else begin
         arr_q    <= arr_d;
         shadow_q <= shadow_d;
      end
   end
`else
   logic unused_commit;
   assign unused_commit = commit;

   // Write the accepted word directly into the visible array.
   always_comb begin
      arr_d = arr_q;
      if (wr_en) begin
         arr_d[wr_addr] = wr_data;
      end
   end

   // Register the visible array; reset clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CHANNEL_NUM; i++) begin
            arr_q[i] <= '0;
         end
      end else begin
         arr_q <= arr_d;
      end
   end
`endif

   assign data_out = arr_q;

endmodule

// File: rtl/rprelu_para_loader.sv
// Write side of the RPReLU parameter interface. In reload mode it accepts a serial
// stream beta[0..N-1], gamma[0..N-1], zeta[0..N-1] and fills three per-channel banks
// that drive the RPReLU layer in parallel. Switching to calculate mode mid-load aborts
// the load and raises the sticky load_err flag.
// Optional feature macro: RPRELU_PARA_SHADOW_EN (outputs update atomically at load end).
`ifndef PARA_WIDTH
`define PARA_WIDTH 16
`endif

module rprelu_para_loader
   import rprelu_pkg::*;
#(
   parameter int CHANNEL_NUM = 512,
   parameter int PARA_WIDTH  = `PARA_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         mode,
   input  logic signed [PARA_WIDTH-1:0] para_in,
   input  logic                         para_valid,
   output logic                         para_ready,
   output logic signed [PARA_WIDTH-1:0] rprelu_beta  [CHANNEL_NUM],
   output logic signed [PARA_WIDTH-1:0] rprelu_gamma [CHANNEL_NUM],
   output logic signed [PARA_WIDTH-1:0] rprelu_zeta  [CHANNEL_NUM],
   output logic                         load_done,
   output logic                         load_err
);

   localparam int              CNT_W   = $clog2(CHANNEL_NUM);
   localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(CHANNEL_NUM - 1);

   rprelu_ld_state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             load_done_q, load_done_d;
   logic             load_err_q, load_err_d;
   logic             accept;
   logic             final_accept;

   // Handshake: ready only while loading and the layer is not asking for calculate mode.
   always_comb begin
      para_ready   = ((state_q == LOAD_BETA) || (state_q == LOAD_GAMMA) ||
                      (state_q == LOAD_ZETA)) && (mode == MODE_RELOAD);
      accept       = para_valid && para_ready;
      final_accept = accept && (state_q == LOAD_ZETA) && (cnt_q == LAST_CH);
   end

   // Next-state logic: section sequencing, channel counting, abort and flag updates.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      load_done_d = 1'b0;
      load_err_d  = load_err_q;
      unique case (state_q)
         IDLE: begin
            if (mode == MODE_RELOAD) begin
               state_d    = LOAD_BETA;
               cnt_d      = '0;
               load_err_d = 1'b0;
            end
         end
         LOAD_BETA, LOAD_GAMMA, LOAD_ZETA: begin
            if (mode == MODE_CALC) begin
               state_d    = IDLE;
               cnt_d      = '0;
               load_err_d = 1'b1;
            end else if (accept) begin
               if (cnt_q == LAST_CH) begin
                  cnt_d = '0;
                  if (state_q == LOAD_BETA) begin
                     state_d = LOAD_GAMMA;
                  end else if (state_q == LOAD_GAMMA) begin
                     state_d = LOAD_ZETA;
                  end else begin
                     state_d     = DONE;
                     load_done_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         DONE: begin
            if (mode == MODE_CALC) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State, counter and registered flags; reset returns everything to idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         load_done_q <= load_done_d;
         load_err_q  <= load_err_d;
      end
   end

   assign load_done = load_done_q;
   assign load_err  = load_err_q;

   rprelu_para_bank #(
      .CHANNEL_NUM (CHANNEL_NUM),
      .PARA_WIDTH  (PARA_WIDTH),
      .CNT_W       (CNT_W)
   ) u_beta_bank (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (accept && (state_q == LOAD_BETA)),
      .wr_addr  (cnt_q),
      .wr_data  (para_in),
      .commit   (final_accept),
      .data_out (rprelu_beta)
   );

   rprelu_para_bank #(
      .CHANNEL_NUM (CHANNEL_NUM),
      .PARA_WIDTH  (PARA_WIDTH),
      .CNT_W       (CNT_W)
   ) u_gamma_bank (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (accept && (state_q == LOAD_GAMMA)),
      .wr_addr  (cnt_q),
      .wr_data  (para_in),
      .commit   (final_accept),
      .data_out (rprelu_gamma)
   );

   rprelu_para_bank #(
      .CHANNEL_NUM (CHANNEL_NUM),
      .PARA_WIDTH  (PARA_WIDTH),
      .CNT_W       (CNT_W)
   ) u_zeta_bank (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (accept && (state_q == LOAD_ZETA)),
      .wr_addr  (cnt_q),
      .wr_data  (para_in),
      .commit   (final_accept),
      .data_out (rprelu_zeta)
   );

endmodule

// File: tb/tb_rprelu_para_loader.sv
// Self-checking bench for rprelu_para_loader with CHANNEL_NUM=4, PARA_WIDTH=16.
// Expected arrays come from a stream-level model: each accepted word is the k-th
// word of the stream and belongs to section k/N, channel k%N.
module tb_rprelu_para_loader;
   import rprelu_pkg::*;

   localparam int N     = 4;
   localparam int W     = 16;
   localparam int TOTAL = SECTION_NUM * N;

   logic                clk = 1'b0;
   logic                rst;
   logic                mode;
   logic signed [W-1:0] para_in;
   logic                para_valid;
   logic                para_ready;
   logic signed [W-1:0] rprelu_beta  [N];
   logic signed [W-1:0] rprelu_gamma [N];
   logic signed [W-1:0] rprelu_zeta  [N];
   logic                load_done;
   logic                load_err;

   int compared   = 0;
   int mismatched = 0;
   int done_seen  = 0;

   logic [W-1:0] exp_arr [SECTION_NUM][N];
   logic [W-1:0] pending [TOTAL];
   logic [W-1:0] got     [SECTION_NUM][N];
   int           acc_cnt;
   logic         exp_err;

   always #5 clk = ~clk;

   rprelu_para_loader #(
      .CHANNEL_NUM (N),
      .PARA_WIDTH  (W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .mode         (mode),
      .para_in      (para_in),
      .para_valid   (para_valid),
      .para_ready   (para_ready),
      .rprelu_beta  (rprelu_beta),
      .rprelu_gamma (rprelu_gamma),
      .rprelu_zeta  (rprelu_zeta),
      .load_done    (load_done),
      .load_err     (load_err)
   );

   // Collect the three output arrays into one indexable view.
   always_comb begin
      for (int c = 0; c < N; c++) begin
         got[0][c] = rprelu_beta[c];
         got[1][c] = rprelu_gamma[c];
         got[2][c] = rprelu_zeta[c];
      end
   end

   // Count cycles in which load_done is seen high.
   always @(negedge clk) begin
      if (load_done === 1'b1) done_seen++;
   end

   // Keep the run bounded even if the design stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic void model_reset();
      for (int s = 0; s < SECTION_NUM; s++)
         for (int c = 0; c < N; c++) exp_arr[s][c] = '0;
      acc_cnt = 0;
      exp_err = 1'b0;
   endfunction

   function automatic void model_start();
      acc_cnt = 0;
      exp_err = 1'b0;
   endfunction

   function automatic void model_abort();
      acc_cnt = 0;
      exp_err = 1'b1;
   endfunction

   function automatic void model_accept(input logic [W-1:0] w);
      pending[acc_cnt] = w;
`ifndef RPRELU_PARA_SHADOW_EN
      exp_arr[acc_cnt / N][acc_cnt % N] = w;
`endif
      acc_cnt++;
      if (acc_cnt == TOTAL) begin
         for (int k = 0; k < TOTAL; k++) exp_arr[k / N][k % N] = pending[k];
         acc_cnt = 0;
      end
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   // Present one word and wait (bounded) for ready; returns one cycle after the accept edge.
   task automatic send_word(input logic [W-1:0] w);
      int guard = 0;
      para_in    = w;
      para_valid = 1'b1;
      while (para_ready !== 1'b1 && guard < 8) begin
         step();
         guard++;
      end
      compared++;
      if (para_ready !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL send_ready: got %b want 1", para_ready);
      end else begin
         model_accept(w);
      end
      step();
   endtask

   // Leave DONE/IDLE through calculate mode and start a fresh load.
   task automatic restart();
      para_valid = 1'b0;
      mode       = MODE_CALC;
      step();
      mode = MODE_RELOAD;
      model_start();
      step();
   endtask

   task automatic test_reset();
      model_reset();
      compared += 3;
      if (para_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ready: got %b want 0", para_ready); end
      if (load_done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b want 0", load_done); end
      if (load_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err: got %b want 0", load_err); end
      for (int s = 0; s < SECTION_NUM; s++)
         for (int c = 0; c < N; c++) begin
            compared++;
            if (got[s][c] !== exp_arr[s][c]) begin
               mismatched++;
               $display("[TB] FAIL reset_arr[%0d][%0d]: got %h want %h", s, c, got[s][c], exp_arr[s][c]);
            end
         end
   endtask

   task automatic test_back_to_back();
      int snap;
      mode = MODE_RELOAD;
      model_start();
      step();
      compared += 2;
      if (para_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_start_ready: got %b want 1", para_ready); end
      if (load_err !== exp_err) begin mismatched++; $display("[TB] FAIL b2b_start_err: got %b want %b", load_err, exp_err); end
      snap = done_seen;
      for (int i = 1; i <= TOTAL; i++) send_word(W'(i));
      compared += 2;
      if (load_done !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_done: got %b want 1", load_done); end
      if (para_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_ready_in_done: got %b want 0", para_ready); end
      for (int s = 0; s < SECTION_NUM; s++)
         for (int c = 0; c < N; c++) begin
            compared++;
            if (got[s][c] !== exp_arr[s][c]) begin
               mismatched++;
               $display("[TB] FAIL b2b_arr[%0d][%0d]: got %h want %h", s, c, got[s][c], exp_arr[s][c]);
            end
         end
      step();
      step();
      compared += 2;
      if (load_done !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_done_width: got %b want 0", load_done); end
      if (done_seen - snap !== 1) begin mismatched++; $display("[TB] FAIL b2b_done_count: got %0d want 1", done_seen - snap); end
   endtask

   task automatic test_toggle_valid();
      int snap;
      restart();
      snap = done_seen;
      for (int i = 1; i <= TOTAL; i++) begin
         send_word(W'(i));
         if (i < TOTAL) begin
            para_valid = 1'b0;
            compared++;
            if (load_done !== 1'b0) begin mismatched++; $display("[TB] FAIL toggle_early_done: got %b want 0", load_done); end
            step();
         end
      end
      para_valid = 1'b0;
      compared++;
      if (load_done !== 1'b1) begin mismatched++; $display("[TB] FAIL toggle_done: got %b want 1", load_done); end
      for (int s = 0; s < SECTION_NUM; s++)
         for (int c = 0; c < N; c++) begin
            compared++;
            if (got[s][c] !== exp_arr[s][c]) begin
               mismatched++;
               $display("[TB] FAIL toggle_arr[%0d][%0d]: got %h want %h", s, c, got[s][c], exp_arr[s][c]);
            end
         end
      step();
      step();
      compared++;
      if (done_seen - snap !== 1) begin mismatched++; $display("[TB] FAIL toggle_done_count: got %0d want 1", done_seen - snap); end
   endtask

   task automatic test_abort();
      para_valid = 1'b0;
      mode       = MODE_CALC;
      rst        = 1'b1;
      step();
      rst = 1'b0;
      model_reset();
      mode = MODE_RELOAD;
      model_start();
      step();
      for (int i = 1; i <= 6; i++) send_word(W'(i));
      mode       = MODE_CALC;
      para_in    = W'(7);
      para_valid = 1'b1;
      model_abort();
      step();
      compared += 3;
      if (para_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_ready: got %b want 0", para_ready); end
      if (load_err !== exp_err) begin mismatched++; $display("[TB] FAIL abort_err: got %b want %b", load_err, exp_err); end
      if (load_done !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_done: got %b want 0", load_done); end
      for (int s = 0; s < SECTION_NUM; s++)
         for (int c = 0; c < N; c++) begin
            compared++;
            if (got[s][c] !== exp_arr[s][c]) begin
               mismatched++;
               $display("[TB] FAIL abort_arr[%0d][%0d]: got %h want %h", s, c, got[s][c], exp_arr[s][c]);
            end
         end
      step();
      compared += 2;
      if (para_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_idle_ready: got %b want 0", para_ready); end
      if (load_err !== 1'b1) begin mismatched++; $display("[TB] FAIL abort_sticky_err: got %b want 1", load_err); end
      para_valid = 1'b0;
   endtask

   task automatic test_reload_signed();
      mode = MODE_RELOAD;
      model_start();
      step();
      compared += 2;
      if (load_err !== exp_err) begin mismatched++; $display("[TB] FAIL reload_err_clear: got %b want %b", load_err, exp_err); end
      if (para_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reload_ready: got %b want 1", para_ready); end
      for (int k = 0; k < TOTAL; k++) send_word(W'(k - 16));
      para_valid = 1'b0;
      compared += 2;
      if (load_done !== 1'b1) begin mismatched++; $display("[TB] FAIL reload_done: got %b want 1", load_done); end
      if ($signed(rprelu_zeta[N-1]) != -5) begin mismatched++; $display("[TB] FAIL reload_signed_last: got %0d want -5", $signed(rprelu_zeta[N-1])); end
      for (int s = 0; s < SECTION_NUM; s++)
         for (int c = 0; c < N; c++) begin
            compared++;
            if (got[s][c] !== exp_arr[s][c]) begin
               mismatched++;
               $display("[TB] FAIL reload_arr[%0d][%0d]: got %h want %h", s, c, got[s][c], exp_arr[s][c]);
            end
         end
      step();
      compared++;
      if (load_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reload_err_after: got %b want 0", load_err); end
   endtask

   task automatic test_mid_reset();
      int snap;
      restart();
      snap = done_seen;
      for (int i = 0; i < 8; i++) send_word(W'($urandom));
      rst        = 1'b1;
      para_valid = 1'b1;
      step();
      model_reset();
      rst        = 1'b0;
      mode       = MODE_CALC;
      para_valid = 1'b0;
      compared += 2;
      if (para_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_ready: got %b want 0", para_ready); end
      if (load_err !== exp_err) begin mismatched++; $display("[TB] FAIL midrst_err: got %b want %b", load_err, exp_err); end
      for (int s = 0; s < SECTION_NUM; s++)
         for (int c = 0; c < N; c++) begin
            compared++;
            if (got[s][c] !== exp_arr[s][c]) begin
               mismatched++;
               $display("[TB] FAIL midrst_arr[%0d][%0d]: got %h want %h", s, c, got[s][c], exp_arr[s][c]);
            end
         end
      repeat (4) step();
      compared++;
      if (done_seen !== snap) begin mismatched++; $display("[TB] FAIL midrst_done_count: got %0d want %0d", done_seen, snap); end
   endtask

   task automatic test_random_stream();
      restart();
      for (int k = 0; k < TOTAL; k++) begin
         int bubbles = $urandom_range(0, 2);
         para_valid = 1'b0;
         para_in    = W'($urandom);
         repeat (bubbles) step();
         send_word(W'($urandom));
         if (k == 6) begin
            for (int s = 0; s < SECTION_NUM; s++)
               for (int c = 0; c < N; c++) begin
                  compared++;
                  if (got[s][c] !== exp_arr[s][c]) begin
                     mismatched++;
                     $display("[TB] FAIL rand_mid_arr[%0d][%0d]: got %h want %h", s, c, got[s][c], exp_arr[s][c]);
                  end
               end
         end
      end
      para_valid = 1'b0;
      compared++;
      if (load_done !== 1'b1) begin mismatched++; $display("[TB] FAIL rand_done: got %b want 1", load_done); end
      for (int s = 0; s < SECTION_NUM; s++)
         for (int c = 0; c < N; c++) begin
            compared++;
            if (got[s][c] !== exp_arr[s][c]) begin
               mismatched++;
               $display("[TB] FAIL rand_arr[%0d][%0d]: got %h want %h", s, c, got[s][c], exp_arr[s][c]);
            end
         end
      step();
   endtask

   task automatic test_hold_in_done();
      int snap;
      snap       = done_seen;
      mode       = MODE_RELOAD;
      para_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         para_in = W'($urandom);
         compared++;
         if (para_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL hold_ready[%0d]: got %b want 0", i, para_ready); end
         step();
      end
      para_valid = 1'b0;
      compared++;
      if (done_seen !== snap) begin mismatched++; $display("[TB] FAIL hold_done_count: got %0d want %0d", done_seen, snap); end
      for (int s = 0; s < SECTION_NUM; s++)
         for (int c = 0; c < N; c++) begin
            compared++;
            if (got[s][c] !== exp_arr[s][c]) begin
               mismatched++;
               $display("[TB] FAIL hold_arr[%0d][%0d]: got %h want %h", s, c, got[s][c], exp_arr[s][c]);
            end
         end
      restart();
      compared += 2;
      if (para_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL hold_restart_ready: got %b want 1", para_ready); end
      if (load_err !== exp_err) begin mismatched++; $display("[TB] FAIL hold_restart_err: got %b want %b", load_err, exp_err); end
   endtask

   initial begin
      rst        = 1'b1;
      mode       = MODE_CALC;
      para_in    = '0;
      para_valid = 1'b0;
      model_reset();
      repeat (2) step();
      test_reset();
      rst = 1'b0;
      test_back_to_back();
      test_toggle_valid();
      test_abort();
      test_reload_signed();
      test_mid_reset();
      test_random_stream();
      test_hold_in_done();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
